z80_uart_io: RTL

I/O-mapped 8N1 UART peripheral that answers Z80 `IN`/`OUT` cycles at ports 0x84 (data) and 0x85 (status/control). It is the responder side of the echo firmware's polling protocol: status bit0 means TX ready and bit1 means RX data available. It sits on the Z80 I/O bus beside the boot ROM and drives the board's serial pins.

---
 rtl/z80_uart_io.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/z80_uart_io.sv
// Z80 I/O-mapped 8N1 UART: data register at ADDR_DATA, status at ADDR_STAT.
// Optional build macro UART_LOOPBACK_EN: the receiver hears the internal TX line and txd is held high.
module z80_uart_io #(
    parameter int         BAUD_DIV  = 104,
    parameter logic [7:0] ADDR_DATA = 8'h84,
    parameter logic [7:0] ADDR_STAT = 8'h85
) (
    input  logic       n_rst,
    input  logic       clk,
    input  logic       n_iorq,
    input  logic       n_rd,
    input  logic       n_wr,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       txd,
    input  logic       rxd,
    output logic [1:0] o_tx_state,
    output logic [1:0] o_rx_state
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode and edge detection
    logic w_sel, w_rd_acc, w_wr_acc, w_rd_rise, w_wr_rise, w_rd_clr;
    logic r_rd_acc_d, r_wr_acc_d, r_rd_is_data;
    logic [7:0] r_data_out;
    logic [7:0] w_status;

    // Transmitter
    state_t          r_tx_state, w_tx_state_nxt;
    logic [CW-1:0]   r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]      r_tx_bit, w_tx_bit_nxt;
    logic [7:0]      r_tx_sh, w_tx_sh_nxt;
    logic            r_tx_line, w_tx_line_nxt;
    logic            w_tx_load, w_tx_wr, w_tx_busy, w_tx_ready;
    logic [7:0]      r_hold;
    logic            r_hold_full;

    // Receiver
    state_t          r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]   r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]      r_rx_bit, w_rx_bit_nxt;
    logic [7:0]      r_rx_sh, w_rx_sh_nxt;
    logic [7:0]      r_rx_byte, w_rx_byte_nxt;
    logic            r_rx_ready, w_rx_ready_nxt;
    logic            r_ovr, w_ovr_nxt;
    logic            r_ferr, w_ferr_nxt;
    logic            r_rx_prev, w_rx_in, w_rx_done;

    assign w_sel     = !n_iorq && (addr == ADDR_DATA || addr == ADDR_STAT);
    assign w_rd_acc  = w_sel && !n_rd;
    assign w_wr_acc  = w_sel && !n_wr;
    assign w_rd_rise = w_rd_acc && !r_rd_acc_d;
    assign w_wr_rise = w_wr_acc && !r_wr_acc_d;
    // Flags clear when a data-register read cycle ends, not when it starts.
    assign w_rd_clr  = !w_rd_acc && r_rd_acc_d && r_rd_is_data;

    assign w_tx_busy  = (r_tx_state != S_IDLE);
    assign w_tx_ready = !r_hold_full;
    assign w_tx_wr    = w_wr_rise && (addr == ADDR_DATA) && !r_hold_full;
    assign w_status   = {3'b000, w_tx_busy, r_ferr, r_ovr, r_rx_ready, w_tx_ready};

    assign data_out   = r_data_out;
    assign data_oe    = r_rd_acc_d;
    assign o_tx_state = r_tx_state;
    assign o_rx_state = r_rx_state;

`ifdef UART_LOOPBACK_EN
    logic w_unused_rxd;
    assign w_unused_rxd = rxd;
    assign w_rx_in      = r_tx_line;
    assign txd          = 1'b1;
`else
    logic r_rx_s1, r_rx_s2;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
        end
    end
    assign w_rx_in = r_rx_s2;
    assign txd     = r_tx_line;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_acc_d   <= 1'b0;
            r_wr_acc_d   <= 1'b0;
            r_rd_is_data <= 1'b0;
            r_data_out   <= 8'h00;
        end else begin
            r_rd_acc_d <= w_rd_acc;
            r_wr_acc_d <= w_wr_acc;
            if (w_rd_rise) r_rd_is_data <= (addr == ADDR_DATA);
            if (w_rd_acc) r_data_out <= (addr == ADDR_DATA) ? r_rx_byte : w_status;
            else          r_data_out <= 8'h00;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_sh_nxt    = r_tx_sh;
        w_tx_line_nxt  = r_tx_line;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt  = '0;
                w_tx_line_nxt = 1'b1;
                w_tx_load     = r_hold_full;
            end
            S_START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_state_nxt = S_DATA;
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_line_nxt  = r_tx_sh[0];
                end
            end
            S_DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = S_STOP;
                        w_tx_line_nxt  = 1'b1;
                    end else begin
                        w_tx_bit_nxt  = r_tx_bit + 3'd1;
                        w_tx_sh_nxt   = {1'b0, r_tx_sh[7:1]};
                        w_tx_line_nxt = r_tx_sh[1];
                    end
                end
            end
            S_STOP: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = S_IDLE;
                    w_tx_load      = r_hold_full;
                end
            end
            default: w_tx_state_nxt = S_IDLE;
        endcase
        // A full holding register chains straight into a new start bit.
        if (w_tx_load) begin
            w_tx_state_nxt = S_START;
            w_tx_cnt_nxt   = '0;
            w_tx_sh_nxt    = r_hold;
            w_tx_line_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= 3'd0;
            r_tx_sh     <= 8'h00;
            r_tx_line   <= 1'b1;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_tx_line  <= w_tx_line_nxt;
            if (w_tx_load) begin
                r_hold_full <= 1'b0;
            end else if (w_tx_wr) begin
                r_hold      <= data_in;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_sh_nxt    = r_rx_sh;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rx_prev && !w_rx_in) w_rx_state_nxt = S_START;
            end
            S_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = 3'd0;
                    w_rx_state_nxt = w_rx_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_sh_nxt  = {w_rx_in, r_rx_sh[7:1]};
                    w_rx_bit_nxt = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = S_IDLE;
                    w_rx_done      = 1'b1;
                end
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase

        // Clear first, so a frame completing in the same clock as the clear is kept.
        w_rx_byte_nxt  = r_rx_byte;
        w_rx_ready_nxt = r_rx_ready;
        w_ovr_nxt      = r_ovr;
        w_ferr_nxt     = r_ferr;
        if (w_rd_clr) begin
            w_rx_ready_nxt = 1'b0;
            w_ovr_nxt      = 1'b0;
            w_ferr_nxt     = 1'b0;
        end
        if (w_rx_done) begin
            if (!w_rx_ready_nxt) begin
                w_rx_byte_nxt  = r_rx_sh;
                w_rx_ready_nxt = 1'b1;
                if (!w_rx_in) w_ferr_nxt = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_sh    <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_ready <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_rx_byte  <= w_rx_byte_nxt;
            r_rx_ready <= w_rx_ready_nxt;
            r_ovr      <= w_ovr_nxt;
            r_ferr     <= w_ferr_nxt;
            r_rx_prev  <= w_rx_in;
        end
    end
endmodule
